pwm_duty_sequencer: RTL

PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_duty_sequencer_core.sv | 47 ++++
 rtl/pwm_duty_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, FSM state type and duty clamp helper for the PWM duty sequencer.
package pwm_pkg;

  localparam int DUTY_W       = 4;
  localparam int DUTY_MIN_DEF = 1;
  localparam int DUTY_MAX_DEF = 9;
  localparam logic [DUTY_W-1:0] DUTY_RESET = 4'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] d,
    input logic [DUTY_W-1:0] lo,
    input logic [DUTY_W-1:0] hi
  );
    logic [DUTY_W-1:0] r;
    if (d < lo) begin
      r = lo;
    end else if (d > hi) begin
      r = hi;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_duty_sequencer_core.sv
// PWM period counter with registered compare output and registered end-of-period flag.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int PERIOD = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out,
  output logic              period_end
);

  localparam logic [3:0] CNT_LAST = 4'(PERIOD - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       pwm_q, pwm_d;
  logic       pe_q, pe_d;

  // Next counter value; the end flag is precomputed so it lines up with cnt_q == CNT_LAST.
  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    pe_d  = (cnt_d == CNT_LAST);
    pwm_d = (cnt_q < duty);
  end

  // Counter, waveform and period-end registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
      pwm_q <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      pe_q  <= pe_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign period_end = pe_q;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Two-requester duty target arbiter that ramps the applied PWM duty one count per step interval.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int PERIOD       = 10,
  parameter int STEP_PERIODS = 4,
  parameter int DUTY_MIN     = DUTY_MIN_DEF,
  parameter int DUTY_MAX     = DUTY_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DUTY_W-1:0] a_duty,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DUTY_W-1:0] b_duty,
  output logic              b_ready,
  output logic [DUTY_W-1:0] duty_cur,
  output logic [DUTY_W-1:0] target,
  output logic              busy,
  output logic              period_end,
  output logic              pwm_out
);

  localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);
  localparam logic [DUTY_W-1:0] DMIN_C = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] DMAX_C = DUTY_W'(DUTY_MAX);

  state_e              state_q, state_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [DUTY_W-1:0]   target_q, target_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                last_b_q, last_b_d;

  logic                grant_a_s, grant_b_s;
  logic [DUTY_W-1:0]   req_s, req_clamped_s, duty_step_s;
  logic                period_end_s;

  // Round-robin: on a tie the requester that was not granted last wins.
  assign grant_a_s = (state_q == IDLE) && a_valid && (!b_valid || last_b_q);
  assign grant_b_s = (state_q == IDLE) && b_valid && (!a_valid || !last_b_q);
  assign req_s         = grant_b_s ? b_duty : a_duty;
  assign req_clamped_s = clamp_duty(req_s, DMIN_C, DMAX_C);
  assign duty_step_s   = (target_q > duty_q) ? (duty_q + 4'd1) : (duty_q - 4'd1);

  // FSM next-state: accept in IDLE, step duty only on the step-interval period end in RAMP.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        if (grant_a_s || grant_b_s) begin
          target_d = req_clamped_s;
          last_b_d = grant_b_s;
          step_d   = '0;
          if (req_clamped_s != duty_q) begin
            state_d = RAMP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RAMP: begin
        if (period_end_s) begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            duty_d = duty_step_s;
            if (duty_step_s == target_q) begin
              state_d = IDLE;
            end else begin
              state_d = RAMP;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end else begin
          step_d = step_q;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      duty_q   <= DUTY_RESET;
      target_q <= DUTY_RESET;
      step_q   <= '0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      last_b_q <= last_b_d;
    end
  end

  pwm_core #(
    .PERIOD(PERIOD)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .duty      (duty_q),
    .pwm_out   (pwm_out),
    .period_end(period_end_s)
  );

  assign a_ready    = grant_a_s;
  assign b_ready    = grant_b_s;
  assign duty_cur   = duty_q;
  assign target     = target_q;
  assign busy       = (state_q == RAMP);
  assign period_end = period_end_s;

endmodule
